// File: rtl/pair_skew_feeder.sv
// pair_skew_feeder: buffers 64-bit beats from the operand buffer, splits each
// beat into two 32-bit lanes and skews lane 1 by one cycle so the operands
// reach a 2-lane systolic edge wavefront-aligned. A transfer runs for a
// programmed number of beats and finishes with a one-cycle done pulse.
module pair_skew_feeder #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  input  logic                in_valid,
  input  logic [2*DATA_W-1:0] in_data,
  output logic                in_ready,
  output logic [DATA_W-1:0]   out_a0,
  output logic                out_v0,
  output logic [DATA_W-1:0]   out_a1,
  output logic                out_v1,
  output logic                busy,
  output logic                done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [LEN_W-1:0]    rem_in_q, rem_in_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [2*DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic [DATA_W-1:0]   a0_q, a0_d;
  logic                v0_q, v0_d;
  logic [DATA_W-1:0]   skew_q, skew_d;
  logic                skew_v_q, skew_v_d;
  logic [DATA_W-1:0]   a1_q, a1_d;
  logic                v1_q, v1_d;

  logic                accept;
  logic                pop;
  logic [2*DATA_W-1:0] head;

  // Handshake and pop qualifiers; the array downstream drains every cycle.
  assign accept = in_valid && in_ready;
  assign pop    = (count_q != '0);
  assign head   = mem_q[rd_ptr_q];

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: a zero-length transfer goes straight to DONE.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = (len == '0) ? S_DONE : S_LOAD;
      S_LOAD:  if (accept && (rem_in_q == LEN_W'(1))) state_d = S_DRAIN;
      S_DRAIN: if ((count_q == '0) && !skew_v_q && !v1_q) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from registered state, count and beat counter only.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    in_ready = (state_q == S_LOAD) && (count_q < CNT_W'(FIFO_DEPTH)) &&
               (rem_in_q != '0);
  end

  // Beat counter, FIFO pointers and occupancy.
  always_comb begin
    rem_in_d = rem_in_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if ((state_q == S_IDLE) && start) rem_in_d = len;
    else if (accept)                  rem_in_d = rem_in_q - LEN_W'(1);

    // Power-of-two depth lets the pointers wrap by plain overflow.
    if (accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);

    unique case ({accept, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Lane split and diagonal skew: element 0 leaves on the pop edge, element 1
  // waits one edge in the skew register. Idle slots drive zero data.
  always_comb begin
    v0_d     = pop;
    a0_d     = pop ? head[2*DATA_W-1:DATA_W] : '0;
    skew_v_d = pop;
    skew_d   = pop ? head[DATA_W-1:0] : '0;
    v1_d     = skew_v_q;
    a1_d     = skew_q;
  end

  // Control and pipeline registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_in_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      a0_q     <= '0;
      v0_q     <= 1'b0;
      skew_q   <= '0;
      skew_v_q <= 1'b0;
      a1_q     <= '0;
      v1_q     <= 1'b0;
    end else begin
      rem_in_q <= rem_in_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      a0_q     <= a0_d;
      v0_q     <= v0_d;
      skew_q   <= skew_d;
      skew_v_q <= skew_v_d;
      a1_q     <= a1_d;
      v1_q     <= v1_d;
    end
  end

  // Beat storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; only entries between
    // the pointers are ever read, and the pointers and count are reset.
    if (accept) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_a0 = a0_q;
  assign out_v0 = v0_q;
  assign out_a1 = a1_q;
  assign out_v1 = v1_q;

endmodule
